// File: rtl/line_follower_pkg.sv
// Shared types and constants for the line-follower actuator controller.
package line_follower_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FORWARD    = 3'd1,
    TURN_LEFT  = 3'd2,
    TURN_RIGHT = 3'd3,
    SEARCH     = 3'd4,
    HALT       = 3'd5
  } state_t;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_SEARCH_TIMEOUT  = 1000;
  localparam int DEFAULT_DUTY_FWD        = 200;
  localparam int DEFAULT_DUTY_TURN       = 128;

endpackage

// File: rtl/line_follower_ctrl_sensor_debounce.sv
// Two-flop synchronizer plus debounce for the {left, right} sensor pair.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raw,
  output logic [1:0] pair
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    meta_reg, sync_reg, prev_reg, pair_reg;
  logic [CW-1:0] cnt_reg, cnt_next;

  // The counter value is "samples seen so far minus one" for the current run.
  always_comb begin
    cnt_next = cnt_reg;
    if (sync_reg != prev_reg) begin
      cnt_next = '0;
    end else if (cnt_reg != CW'(DEBOUNCE_CYCLES)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= 2'b00;
      sync_reg <= 2'b00;
      prev_reg <= 2'b00;
      pair_reg <= 2'b00;
      cnt_reg  <= '0;
    end else begin
      meta_reg <= raw;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
      cnt_reg  <= cnt_next;
      if (cnt_next == CW'(DEBOUNCE_CYCLES - 1)) begin
        pair_reg <= sync_reg;
      end
    end
  end

  assign pair = pair_reg;

endmodule

// File: rtl/line_follower_ctrl.sv
// Line-follower steering FSM with registered PWM motor outputs.
module line_follower_ctrl
  import line_follower_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SEARCH_TIMEOUT  = DEFAULT_SEARCH_TIMEOUT,
  parameter int PWM_WIDTH       = 8,
  parameter int DUTY_FWD        = DEFAULT_DUTY_FWD,
  parameter int DUTY_TURN       = DEFAULT_DUTY_TURN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sens_l,
  input  logic       sens_r,
  output logic       motor_l,
  output logic       motor_r,
  output logic [2:0] state_o,
  output logic       lost
);

  localparam int SW = $clog2(SEARCH_TIMEOUT + 1);
  localparam logic [PWM_WIDTH-1:0] FWD  = PWM_WIDTH'(DUTY_FWD);
  localparam logic [PWM_WIDTH-1:0] TURN = PWM_WIDTH'(DUTY_TURN);

  logic [1:0]           pair;
  state_t               state_reg, state_next;
  logic                 dir_reg, dir_next;
  logic [SW-1:0]        search_reg, search_next;
  logic [PWM_WIDTH-1:0] pwm_reg, duty_l, duty_r;
  logic                 motor_l_reg, motor_r_reg, lost_reg;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk   (clk),
    .reset (reset),
    .raw   ({sens_l, sens_r}),
    .pair  (pair)
  );

  always_comb begin
    state_next  = state_reg;
    dir_next    = dir_reg;
    search_next = search_reg;
    if (!enable) begin
      state_next = IDLE;
    end else if (state_reg == HALT) begin
      state_next = HALT;
    end else begin
      case (pair)
        2'b11: state_next = FORWARD;
        2'b10: begin
          state_next = TURN_LEFT;
          dir_next   = LEFT;
        end
        2'b01: begin
          state_next = TURN_RIGHT;
          dir_next   = RIGHT;
        end
        default: begin
          // A line reappearing on the timeout edge is handled above, so it wins.
          if (state_reg != SEARCH) begin
            state_next  = SEARCH;
            search_next = '0;
          end else if (search_reg == SW'(SEARCH_TIMEOUT - 1)) begin
            state_next = HALT;
          end else begin
            search_next = search_reg + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    duty_l = '0;
    duty_r = '0;
    case (state_reg)
      FORWARD: begin
        duty_l = FWD;
        duty_r = FWD;
      end
      TURN_LEFT:  duty_r = TURN;
      TURN_RIGHT: duty_l = TURN;
      SEARCH: begin
        if (dir_reg == LEFT) duty_r = TURN;
        else                 duty_l = TURN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      dir_reg     <= RIGHT;
      search_reg  <= '0;
      pwm_reg     <= '0;
      motor_l_reg <= 1'b0;
      motor_r_reg <= 1'b0;
      lost_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dir_reg     <= dir_next;
      search_reg  <= search_next;
      pwm_reg     <= pwm_reg + 1'b1;
      motor_l_reg <= (pwm_reg < duty_l);
      motor_r_reg <= (pwm_reg < duty_r);
      lost_reg    <= (state_next == HALT);
    end
  end

  assign motor_l = motor_l_reg;
  assign motor_r = motor_r_reg;
  assign state_o = state_reg;
  assign lost    = lost_reg;

endmodule
